// File: rtl/instr_encoder.sv
// instr_encoder: expands host block commands into the 64-bit instruction
// stream sampled every clock by the instruction-decode controller.
// Word layout: [63:59] opcode, [58:43] address, [42:27] data, [26:0] zero.
// Optional build macro ENC_NOP_GAP_EN inserts one NOP cycle (GAP state)
// after every issued instruction except the last one of a command.
//
// Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
// a payload word transfers on an edge where data_valid && data_ready.
// cmd_ready depends only on FSM state and data_ready depends only on FSM
// state and the latched op, so neither has a combinational path from the
// corresponding valid input.
module instr_encoder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int OUT_ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [63:0]       instruction,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam int SUM_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
    localparam int PAD_W = 64 - 5 - ADDR_W - DATA_W;

`ifdef ENC_NOP_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1} state_t;
`endif

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    rem_q, rem_d;      // instructions still to issue
    logic [CNT_W-1:0]    idx_q, idx_d;      // index of next instruction
    logic [63:0]         instr_q, instr_d;
    logic                done_q, done_d;

    logic                is_load;
    logic                slot;
    logic [4:0]          opcode;
    logic [SUM_W-1:0]    mem_sum;
    logic [OUT_ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0]   addr_field;
    logic [DATA_W-1:0]   data_field;
    logic [63:0]         word;

    assign is_load = (op_q == 3'd0) || (op_q == 3'd1);
    // A load instruction can only issue when its payload word is present.
    assign slot    = (state_q == S_ISSUE) && (!is_load || data_valid);

    // Map the latched command op onto the controller opcode.
    always_comb begin
        opcode = 5'b00000;
        case (op_q)
            3'd0:    opcode = 5'b00100;
            3'd1:    opcode = 5'b00101;
            3'd2:    opcode = 5'b00010;
            3'd3:    opcode = 5'b00001;
            3'd4:    opcode = 5'b00011;
            3'd5:    opcode = 5'b00110;
            default: opcode = 5'b00000;
        endcase
    end

    // Memory ops wrap over the full address field; output-buffer ops wrap
    // inside the small output-buffer address space.
    assign mem_sum    = SUM_W'(base_q) + SUM_W'(idx_q);
    assign out_addr   = base_q[OUT_ADDR_W-1:0] + idx_q[OUT_ADDR_W-1:0];
    assign addr_field = (op_q >= 3'd4) ? ADDR_W'(out_addr) : mem_sum[ADDR_W-1:0];
    assign data_field = is_load ? data_in : '0;
    assign word       = {opcode, addr_field, data_field, {PAD_W{1'b0}}};

    // Next-state logic: instruction defaults to NOP every cycle because the
    // controller cannot stall; done is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        instr_d = '0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    base_d = cmd_base_addr;
                    rem_d  = cmd_count;
                    idx_d  = '0;
                    if ((cmd_count == '0) || (cmd_op > 3'd5)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (slot) begin
                    instr_d = word;
                    idx_d   = idx_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
`ifdef ENC_NOP_GAP_EN
                        state_d = S_GAP;
`else
                        state_d = S_ISSUE;
`endif
                    end
                end
            end
`ifdef ENC_NOP_GAP_EN
            S_GAP: begin
                state_d = S_ISSUE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            base_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            instr_q <= instr_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign data_ready  = (state_q == S_ISSUE) && is_load;
    assign instruction = instr_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed commands, a word-level reference model
// fed through an expected queue, and a per-cycle compare process.
// Build with ENC_NOP_GAP_EN defined to exercise the gap variant.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_base_addr;
    logic [15:0] cmd_count;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] data_in;
    logic [63:0] instruction;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

`ifdef ENC_NOP_GAP_EN
    localparam int SP = 2;        // cycles between consecutive words
    localparam int RST_WAIT = 4;
`else
    localparam int SP = 1;
    localparam int RST_WAIT = 3;
`endif

    instr_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_base_addr (cmd_base_addr),
        .cmd_count     (cmd_count),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .data_in       (data_in),
        .instruction   (instruction),
        .busy          (busy),
        .done          (done),
        .dbg_state_o   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];
    bit          last_q[$];
    logic [15:0] data_src_q[$];
    logic [15:0] pay_q[$];
    int          zero_pending = 0;
    bit          chk_en = 1'b0;
    bit          rand_phase = 1'b1;
    int          word_cyc_q[$];
    logic [63:0] seen_q[$];
    int          done_cyc = -1;
    int          words_seen = 0;
    int          hs_cnt = 0;
    int          stall_at = -1;
    int          stall_len = 0;
    int          stall_cnt = 0;
    int          acc, acc2, w0, g;
    logic [63:0] e;
    bit          l, exp_done;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: one instruction word from op, base, index and payload.
    function automatic logic [63:0] model_word(input int op, input int base, input int i, input int data);
        int opc, addr, dat;
        case (op)
            0: opc = 4;
            1: opc = 5;
            2: opc = 2;
            3: opc = 1;
            4: opc = 3;
            5: opc = 6;
            default: opc = 0;
        endcase
        if (op <= 3) addr = (base + i) % 65536;
        else         addr = ((base % 16) + i) % 16;
        dat = (op <= 1) ? data : 0;
        return {opc[4:0], addr[15:0], dat[15:0], 27'd0};
    endfunction

    function automatic logic [63:0] seen_at(input int k);
        if (k < seen_q.size()) return seen_q[k];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic int cyc_at(input int k);
        if (k < word_cyc_q.size()) return word_cyc_q[k];
        return -1000;
    endfunction

    // Compare process: every non-NOP word must be the next expected word,
    // and done must mark exactly the last word or a zero-length command.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            if (instruction !== 64'd0) begin
                words_seen++;
                word_cyc_q.push_back(cyc);
                seen_q.push_back(instruction);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h required NOP", instruction);
                end else begin
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    check64("word", instruction, e);
                    check64("done_on_word", done, l);
                    if (l) begin
                        check64("busy_at_done", busy, 0);
                        check64("ready_at_done", cmd_ready, 1);
                        done_cyc = cyc;
                    end
                end
            end else begin
                exp_done = (zero_pending > 0);
                check64("done_on_nop", done, exp_done);
                if (exp_done) begin
                    zero_pending--;
                    if (done) done_cyc = cyc;
                end
            end
        end
    end

    // Payload driver: offers queued words, honours an injected stall.
    initial begin
        data_valid = 1'b0;
        data_in    = '0;
        forever begin
            @(posedge clk);
            if (data_valid && data_ready === 1'b1 && !rst) begin
                void'(data_src_q.pop_front());
                hs_cnt++;
                if (hs_cnt == stall_at) stall_cnt = stall_len;
            end
            #1;
            if (rand_phase) begin
                data_valid = 1'($urandom_range(0, 1));
                data_in    = 16'($urandom_range(0, 65535));
            end else if (stall_cnt > 0) begin
                data_valid = 1'b0;
                stall_cnt--;
            end else if (data_src_q.size() > 0) begin
                data_valid = 1'b1;
                data_in    = data_src_q[0];
            end else begin
                data_valid = 1'b0;
            end
        end
    end

    // Issue one command; returns the cycle index in which it was accepted.
    task automatic send_cmd(input int op, input int base, input int count, output int acc_o);
        int guard;
        int dat;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_ready_timeout: waited %0d cycles, required ready", guard);
        end
        cmd_valid     = 1'b1;
        cmd_op        = op[2:0];
        cmd_base_addr = base[15:0];
        cmd_count     = count[15:0];
        acc_o         = cyc + 1;
        if (count > 0 && op <= 5) begin
            for (int i = 0; i < count; i++) begin
                dat = 0;
                if (op <= 1) begin
                    dat = int'(pay_q.pop_front());
                    data_src_q.push_back(dat[15:0]);
                end
                exp_q.push_back(model_word(op, base, i, dat));
                last_q.push_back(i == count - 1);
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (count == 0 || op > 5) zero_pending++;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || zero_pending != 0 || cmd_ready !== 1'b1) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check_int({name, "_drain"}, exp_q.size() + zero_pending, 0);
        @(posedge clk); #1;
        check64({name, "_nop_after"}, instruction, 64'd0);
    endtask

    task automatic clear_log();
        seen_q.delete();
        word_cyc_q.delete();
        done_cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_base_addr = '0;
        cmd_count = '0;

        // Reset held 5 cycles with random command inputs.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            cmd_valid     = 1'($urandom_range(0, 1));
            cmd_op        = 3'($urandom_range(0, 7));
            cmd_base_addr = 16'($urandom_range(0, 65535));
            cmd_count     = 16'($urandom_range(0, 65535));
            check64("rst_instr", instruction, 64'd0);
            check64("rst_ready", cmd_ready, 1);
            check64("rst_busy", busy, 0);
            check64("rst_done", done, 0);
            check64("rst_dready", data_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        rand_phase = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check64("post_rst_instr", instruction, 64'd0);
        check64("post_rst_busy", busy, 0);

        // Model pins against hand-computed words.
        check64("model_load_inp", model_word(0, 16'h0010, 0, 16'hAAAA), 64'h2000_8555_5000_0000);
        check64("model_store_wrap", model_word(4, 16'h000E, 2, 0), 64'h1800_0000_0000_0000);
        check64("model_mac_wrap", model_word(3, 16'hFFFF, 1, 0), 64'h0800_0000_0000_0000);

        // LOAD_INP base 0x0010 count 3, payload always valid.
        clear_log();
        pay_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_cmd(0, 16'h0010, 3, acc);
        @(posedge clk); #1;
        check64("busy_in_issue", busy, 1);
        check64("ready_in_issue", cmd_ready, 0);
        wait_idle("load_inp");
        check_int("li_count", seen_q.size(), 3);
        check64("li_w0", seen_at(0), 64'h2000_8555_5000_0000);
        check64("li_w1", seen_at(1), 64'h2000_8DDD_D800_0000);
        check64("li_w2", seen_at(2), 64'h2000_9666_6000_0000);
        check_int("li_first_latency", cyc_at(0), acc + 2);
        check_int("li_spacing1", cyc_at(1) - cyc_at(0), SP);
        check_int("li_spacing2", cyc_at(2) - cyc_at(1), SP);
        check_int("li_done_cycle", done_cyc, cyc_at(2));

        // LOAD_WT count 4 with a 2-cycle payload stall after word 1.
        clear_log();
        hs_cnt = 0;
        stall_at = 1;
        stall_len = 2;
        pay_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_cmd(1, 16'h0100, 4, acc);
        wait_idle("load_wt");
        stall_at = -1;
        check_int("lw_count", seen_q.size(), 4);
        check_int("lw_stall_gap", cyc_at(1) - cyc_at(0), 3);
        check_int("lw_spacing2", cyc_at(2) - cyc_at(1), SP);
        check_int("lw_spacing3", cyc_at(3) - cyc_at(2), SP);
        check_int("lw_transfers", hs_cnt, 4);

        // STORE_OUT wraps inside the output buffer.
        clear_log();
        send_cmd(4, 16'h000E, 4, acc);
        wait_idle("store_out");
        check64("so_w0", seen_at(0), 64'h1800_7000_0000_0000);
        check64("so_w1", seen_at(1), 64'h1800_7800_0000_0000);
        check64("so_w2", seen_at(2), 64'h1800_0000_0000_0000);
        check64("so_w3", seen_at(3), 64'h1800_0800_0000_0000);

        // MAC wraps the full address field.
        clear_log();
        send_cmd(3, 16'hFFFF, 2, acc);
        wait_idle("mac_wrap");
        check64("mw_w0", seen_at(0), 64'h0FFF_F800_0000_0000);
        check64("mw_w1", seen_at(1), 64'h0800_0000_0000_0000);

        // Zero count and reserved op: done at T+1, no words.
        clear_log();
        send_cmd(3, 16'h1234, 0, acc);
        wait_idle("zero_count");
        check_int("zc_done_cycle", done_cyc, acc + 1);
        check_int("zc_words", seen_q.size(), 0);
        clear_log();
        send_cmd(7, 16'h4321, 5, acc);
        wait_idle("reserved");
        check_int("rs_done_cycle", done_cyc, acc + 1);
        check_int("rs_words", seen_q.size(), 0);

        // Command offered while busy is ignored.
        clear_log();
        send_cmd(2, 16'h0200, 6, acc);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op = 3'd5;
        cmd_base_addr = 16'h3333;
        cmd_count = 16'd9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_idle("busy_ignore");
        check_int("bi_words", seen_q.size(), 6);

        // Back-to-back: second command accepted in the done cycle.
        clear_log();
        send_cmd(2, 16'h0300, 2, acc);
        send_cmd(2, 16'h0400, 2, acc2);
        wait_idle("back_to_back");
        check_int("bb_accept_in_done", acc2, cyc_at(1));
        check_int("bb_words", seen_q.size(), 4);

        // MAC count 3 spacing (MAC,NOP,MAC,NOP,MAC in gap builds).
        clear_log();
        send_cmd(3, 16'h0500, 3, acc);
        wait_idle("mac3");
        check_int("m3_spacing1", cyc_at(1) - cyc_at(0), SP);
        check_int("m3_spacing2", cyc_at(2) - cyc_at(1), SP);

        // Reset in the middle of MAC count 10.
        clear_log();
        w0 = words_seen;
        send_cmd(3, 16'h0040, 10, acc);
        g = 0;
        while (words_seen < w0 + RST_WAIT && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        last_q.delete();
        check64("mr_instr_nop", instruction, 64'd0);
        check64("mr_busy", busy, 0);
        check64("mr_done", done, 0);
        check64("mr_ready", cmd_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_int("mr_words", seen_q.size(), 4);

        // A fresh command after the abandoned one issues normally.
        clear_log();
        send_cmd(2, 16'h0077, 1, acc);
        wait_idle("after_rst");
        check64("ar_w0", seen_at(0), 64'h1003_B800_0000_0000);
        check_int("ar_latency", cyc_at(0), acc + 2);
        check_int("ar_done_cycle", done_cyc, cyc_at(0));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
